// File: rtl/controller_sequencer_if.sv
// Opcode/control-word bundle between the SAP-1 sequencer and the datapath.
// master = sequencer side, slave = datapath side.
interface controller_sequencer_if;
  logic [3:0]  instruction;
  logic [11:0] CON;
  logic [5:0]  T;
  logic        HLT;

  modport master (input instruction, output CON, output T, output HLT);
  modport slave  (output instruction, input CON, input T, input HLT);
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot ring (T1..T6) decoding the
// opcode nibble into the 12-bit control word; HLT parks the ring until CLR.
module controller_sequencer (
  input  logic                      CLK,
  input  logic                      CLR,
  controller_sequencer_if.master    bus
);

  typedef enum logic [5:0] {
    S_HALT = 6'b000000,
    S_T1   = 6'b000001,
    S_T2   = 6'b000010,
    S_T3   = 6'b000100,
    S_T4   = 6'b001000,
    S_T5   = 6'b010000,
    S_T6   = 6'b100000
  } state_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Bits: C_P E_P L_M_bar E_R_bar L_I_bar E_I_bar L_A_bar E_A S_U E_U L_B_bar L_O_bar
  localparam logic [11:0] CON_IDLE  = 12'h3E3;
  localparam logic [11:0] CON_ADDR  = 12'h5E3;
  localparam logic [11:0] CON_INCR  = 12'hBE3;
  localparam logic [11:0] CON_MEM   = 12'h263;
  localparam logic [11:0] CON_IR2M  = 12'h1A3;
  localparam logic [11:0] CON_OUT   = 12'h3F2;
  localparam logic [11:0] CON_R2A   = 12'h2C3;
  localparam logic [11:0] CON_R2B   = 12'h2E1;
  localparam logic [11:0] CON_ADD   = 12'h3C7;
  localparam logic [11:0] CON_SUB   = 12'h3CF;

  state_e      state_q, state_d;
  logic        hlt_q, hlt_d;
  logic [11:0] con;
  logic [3:0]  op;

  assign op = bus.instruction;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_T1;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hlt_q   <= hlt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hlt_d   = hlt_q;
    con     = CON_IDLE;
    case (state_q)
      S_T1: begin
        state_d = S_T2;
        con     = CON_ADDR;
      end
      S_T2: begin
        state_d = S_T3;
        con     = CON_INCR;
      end
      S_T3: begin
        state_d = S_T4;
        con     = CON_MEM;
      end
      S_T4: begin
        if (op == OP_HLT) begin
          state_d = S_HALT;
          hlt_d   = 1'b1;
        end else begin
          state_d = S_T5;
        end
        case (op)
          OP_LDA, OP_ADD, OP_SUB: con = CON_IR2M;
          OP_OUT:                 con = CON_OUT;
          default:                con = CON_IDLE;
        endcase
      end
      S_T5: begin
        state_d = S_T6;
        case (op)
          OP_LDA:         con = CON_R2A;
          OP_ADD, OP_SUB: con = CON_R2B;
          default:        con = CON_IDLE;
        endcase
      end
      S_T6: begin
        state_d = S_T1;
        case (op)
          OP_ADD:  con = CON_ADD;
          OP_SUB:  con = CON_SUB;
          default: con = CON_IDLE;
        endcase
      end
      S_HALT: state_d = S_HALT;
      // Non-one-hot encodings are unreachable; recover into fetch if ever seen.
      default: state_d = S_T1;
    endcase
    if (CLR) con = CON_IDLE;
  end

  assign bus.CON = con;
  assign bus.T   = state_q;
  assign bus.HLT = hlt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: table vectors, hand sequences for halt/CLR
// corners, and random stimulus against a step-counter reference model.
module tb_controller_sequencer;

  logic CLK = 1'b0;
  logic CLR;
  controller_sequencer_if bus ();

  controller_sequencer dut (.CLK(CLK), .CLR(CLR), .bus(bus));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: step 0..5 = T1..T6, plus a halted flag.
  int  m_step   = 0;
  bit  m_halted = 1'b0;
  bit  m_hlt    = 1'b0;
  bit  m_known  = 1'b0;

  typedef struct {
    logic [3:0]       ins;
    logic [5:0][11:0] con;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(logic [3:0] ins, logic [11:0] c4, logic [11:0] c5, logic [11:0] c6);
    vec_t v;
    v.ins = ins;
    v.con[0] = 12'h5E3; v.con[1] = 12'hBE3; v.con[2] = 12'h263;
    v.con[3] = c4;      v.con[4] = c5;      v.con[5] = c6;
    return v;
  endfunction

  function automatic logic [11:0] model_con(int step, bit halted, logic clr, logic [3:0] ins);
    if (clr || halted) return 12'h3E3;
    case (step)
      0: return 12'h5E3;
      1: return 12'hBE3;
      2: return 12'h263;
      3: if (ins == 4'h0 || ins == 4'h1 || ins == 4'h2) return 12'h1A3;
         else if (ins == 4'hE) return 12'h3F2;
         else return 12'h3E3;
      4: if (ins == 4'h0) return 12'h2C3;
         else if (ins == 4'h1 || ins == 4'h2) return 12'h2E1;
         else return 12'h3E3;
      5: if (ins == 4'h1) return 12'h3C7;
         else if (ins == 4'h2) return 12'h3CF;
         else return 12'h3E3;
      default: return 12'h3E3;
    endcase
  endfunction

  task automatic check(string name, logic [11:0] got, logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Apply inputs after the falling edge, then compare against the model.
  task automatic drive(logic clr, logic [3:0] ins);
    @(negedge CLK);
    CLR = clr;
    bus.instruction = ins;
    #1;
    check("model_CON", bus.CON, model_con(m_step, m_halted, clr, ins));
    if (m_known) begin
      check("model_T", {6'd0, bus.T}, m_halted ? 12'd0 : 12'(1 << m_step));
      check("model_HLT", {11'd0, bus.HLT}, {11'd0, m_hlt});
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    if (CLR) begin
      m_step = 0; m_halted = 1'b0; m_hlt = 1'b0; m_known = 1'b1;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_step == 3 && bus.instruction == 4'hF) begin
      m_halted = 1'b1; m_hlt = 1'b1;
    end else begin
      m_step = (m_step + 1) % 6;
    end
  endtask

  task automatic cyc(logic clr, logic [3:0] ins);
    drive(clr, ins);
    adv();
  endtask

  initial begin
    CLR = 1'b1;
    bus.instruction = 4'h0;

    vecs[0] = mk(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    vecs[1] = mk(4'h1, 12'h1A3, 12'h2E1, 12'h3C7);
    vecs[2] = mk(4'h2, 12'h1A3, 12'h2E1, 12'h3CF);
    vecs[3] = mk(4'hE, 12'h3F2, 12'h3E3, 12'h3E3);
    vecs[4] = mk(4'h7, 12'h3E3, 12'h3E3, 12'h3E3);
    vecs[5] = mk(4'hA, 12'h3E3, 12'h3E3, 12'h3E3);

    // Reset and ring: two full rounds of T1..T6 with LDA.
    drive(1'b1, 4'h0);
    check("reset_CON", bus.CON, 12'h3E3);
    adv();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 6; k++) begin
        drive(1'b0, 4'h0);
        check("ring_T", {6'd0, bus.T}, 12'(1 << k));
        check("ring_HLT", {11'd0, bus.HLT}, 12'd0);
        adv();
      end
    end

    // Table-driven decode, one full instruction per entry.
    foreach (vecs[i]) begin
      for (int k = 0; k < 6; k++) begin
        drive(1'b0, vecs[i].ins);
        check($sformatf("tbl_CON_op%h_T%0d", vecs[i].ins, k + 1), bus.CON, vecs[i].con[k]);
        check("tbl_T", {6'd0, bus.T}, 12'(1 << k));
        adv();
      end
    end

    // Halt entry and stickiness.
    for (int k = 0; k < 4; k++) cyc(1'b0, 4'hF);
    drive(1'b0, 4'h1);
    check("halt_T", {6'd0, bus.T}, 12'd0);
    check("halt_HLT", {11'd0, bus.HLT}, 12'd1);
    check("halt_CON", bus.CON, 12'h3E3);
    adv();
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 4'($urandom));
      check("halt_hold_T", {6'd0, bus.T}, 12'd0);
      check("halt_hold_HLT", {11'd0, bus.HLT}, 12'd1);
      adv();
    end
    cyc(1'b1, 4'hF);
    drive(1'b0, 4'h0);
    check("halt_clr_T", {6'd0, bus.T}, 12'h001);
    check("halt_clr_HLT", {11'd0, bus.HLT}, 12'd0);
    adv();
    for (int k = 0; k < 5; k++) cyc(1'b0, 4'h0);

    // CLR during T5 of ADD: no T6 word, straight back to T1.
    for (int k = 0; k < 4; k++) cyc(1'b0, 4'h1);
    drive(1'b1, 4'h1);
    check("midclr_T5_T", {6'd0, bus.T}, 12'h010);
    check("midclr_CON", bus.CON, 12'h3E3);
    adv();
    drive(1'b0, 4'h1);
    check("midclr_next_T", {6'd0, bus.T}, 12'h001);
    check("midclr_next_CON", bus.CON, 12'h5E3);
    adv();
    for (int k = 0; k < 5; k++) cyc(1'b0, 4'h1);

    // CLR and halt entry on the same edge: CLR wins.
    for (int k = 0; k < 3; k++) cyc(1'b0, 4'hF);
    drive(1'b1, 4'hF);
    check("simul_T4_T", {6'd0, bus.T}, 12'h008);
    adv();
    drive(1'b0, 4'hF);
    check("simul_T", {6'd0, bus.T}, 12'h001);
    check("simul_HLT", {11'd0, bus.HLT}, 12'd0);
    adv();

    // Random stimulus against the model.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] ins;
      case ($urandom_range(0, 7))
        0: ins = 4'h0;
        1: ins = 4'h1;
        2: ins = 4'h2;
        3: ins = 4'hE;
        4: ins = 4'hF;
        default: ins = 4'($urandom);
      endcase
      cyc(($urandom_range(0, 19) == 0), ins);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 controller-sequencer: consumes the 4-bit opcode nibble from the instruction register and drives the 12-bit control word that sequences every register, the bus, and the adder-subtracter. A six-state one-hot ring counter (T1..T6) runs the fetch cycle (T1-T3) and the execute cycle (T4-T6) for LDA, ADD, SUB, OUT and HLT. HLT freezes the machine until CLR.

## Interface
- No parameters.
- CLK  in  1  system clock; all state changes on rising edge.
- CLR  in  1  reset, synchronous, active-high.
- instruction  in  4  opcode nibble from the instruction register upper half, used combinationally.
- CON  out  12  control word. Bits 11..0 are C_P, E_P, L_M_bar, E_R_bar, L_I_bar, E_I_bar, L_A_bar, E_A, S_U, E_U, L_B_bar, L_O_bar. Bits ending in _bar are active-low.
- T  out  6  ring state, one-hot; T[0]=T1 .. T[5]=T6.
- HLT  out  1  registered halt flag.

## Operation
- Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111. All others are NOP, so T4-T6 stay idle.
- States: T1 -> T2 -> T3 -> T4 -> T5 -> T6 -> T1, advancing one state per rising edge. HALTED is T=000000.
- CON is decoded combinationally from T and instruction:
  - Idle value is 12'h3E3. It is driven in HALTED, during CLR=1, and in any unlisted state/opcode pair.
  - T1 (address): E_P, L_M_bar -> 12'h5E3.
  - T2 (increment): C_P -> 12'hBE3.
  - T3 (memory): E_R_bar, L_I_bar -> 12'h263.
  - T4, LDA/ADD/SUB: E_I_bar, L_M_bar -> 12'h1A3.
  - T4, OUT: E_A, L_O_bar -> 12'h3F2.
  - T4, HLT: 12'h3E3.
  - T5, LDA: E_R_bar, L_A_bar -> 12'h2C3.
  - T5, ADD/SUB: E_R_bar, L_B_bar -> 12'h2E1.
  - T5, OUT/HLT: 12'h3E3.
  - T6, ADD: E_U, L_A_bar -> 12'h3C7.
  - T6, SUB: S_U, E_U, L_A_bar -> 12'h3CF.
  - T6, LDA/OUT: 12'h3E3.
- Halt entry: at the rising edge leaving T4 with instruction=1111, the next state is HALTED and HLT becomes 1. HALTED is sticky; only CLR exits it.
- Instruction changes outside T4-T6 have no effect on state. Within T4-T6, CON tracks instruction combinationally.
- The one-hot invariant holds at all times except HALTED (all zero). No other encoding is reachable.

## Timing
- Reset: a rising edge with CLR=1 sets T=000001, HLT=0. While CLR=1, CON=12'h3E3 regardless of state.
- After CLR drops, the first rising edge advances T1 -> T2. T1's control word is valid during the first full cycle after release.
- Fetch is 3 cycles and execute is 3 cycles, so every instruction takes exactly 6 cycles, including NOP, LDA and OUT with idle T-states.
- The instruction register loads on the same rising edge that leaves T3. Its new opcode is therefore valid for the T4 decode; no extra latency.
- HLT latency: HLT rises on the edge ending T4, one cycle after T4 entry, and remains 1.
- CLR mid-instruction (any T-state or HALTED): the next rising edge forces T1/HLT=0. CLR has priority over halt entry on the same edge.
- Integration note: the system feeds this block the inverted system clock, so that CON settles half a cycle before the registers' loading edge. This block itself uses rising-edge semantics only.

## Test plan
- Reset and ring: pulse CLR for 1 cycle, instruction=0000, run 12 cycles -> T sequence 01,02,04,08,10,20 repeating twice; HLT=0; CON during CLR = 3E3.
- Fetch words: any opcode -> CON = 5E3, BE3, 263 in T1, T2, T3 respectively.
- Execute decode: opcode 0000 -> 1A3, 2C3, 3E3; 0001 -> 1A3, 2E1, 3C7; 0010 -> 1A3, 2E1, 3CF; 1110 -> 3F2, 3E3, 3E3; 0111 (undefined) -> 3E3 x3.
- Halt:
  - Opcode 1111 at T4 -> next edge T=00, HLT=1, CON=3E3.
  - Holds for 10+ cycles while instruction toggles.
  - CLR=1 for 1 edge -> T=01, HLT=0.
- Reset mid-operation: assert CLR during T5 with opcode 0001 -> next edge T=01; no T6 word (3C7) ever appears.
- Simultaneous: CLR=1 on the edge leaving T4 with opcode 1111 -> T=01, HLT stays 0.
